reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-port integer register file with write-through bypass and a per-register pending-write scoreboard, for the pipelined core. Decode issues destination registers into the scoreboard. Writeback ports write data and retire pending entries. Read ports return bypassed data plus a busy flag, which the hazard unit uses to stall.

## Interface
Parameters:
- D_WIDTH, 32, data width
- ADDRESS_WIDTH, 5, register address width; depth = 2**ADDRESS_WIDTH
- NUM_READ, 2, read ports (1..4)
- NUM_WRITE, 2, writeback ports (1..2)
- PEND_W, 2, pending-counter width per register; max outstanding writes = 2**PEND_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_READ x ADDRESS_WIDTH  read addresses
- rd_data  out  NUM_READ x D_WIDTH  read data, combinational, bypassed
- rd_busy  out  NUM_READ  source still pending after this cycle's writebacks
- iss_valid  in  1  decode requests to mark iss_rd pending
- iss_rd  in  ADDRESS_WIDTH  destination being issued
- iss_ready  out  1  issue accepted this cycle
- wb_valid  in  NUM_WRITE  writeback strobe per port
- wb_addr  in  NUM_WRITE x ADDRESS_WIDTH  writeback destination
- wb_data  in  NUM_WRITE x D_WIDTH  writeback data
- flush  in  1  synchronous clear of all pending counters
- a0  out  D_WIDTH  stored value of register 10, unbypassed, for debug

## Operation
- Register 0 always reads 0.
  - It is never written and never pending.
  - An issue to x0 is accepted, with no effect.
  - A writeback to x0 is ignored and does not count as a hit.
- Writeback: every valid port with nonzero wb_addr writes on the clock edge.
  - If both ports target the same register, port NUM_WRITE-1 wins.
- Hits: hits(r) = number of valid nonzero writeback ports targeting r this cycle (0..NUM_WRITE).
- Counter update for each r != 0 each cycle: cnt' = sat0(cnt - hits(r)) + acc(r).
  - acc(r) = 1 when the issue handshake completes with iss_rd == r.
  - sat0 clamps at 0: a writeback to a register with no pending entry still writes its data and leaves the counter at 0.
- Issue handshake:
  - iss_ready = (iss_rd == 0) || (cnt[iss_rd] != 2**PEND_W-1), from the registered count only.
  - Accepted when iss_valid && iss_ready.
  - iss_ready is independent of iss_valid.
- Read bypass:
  - If any valid writeback hits rd_addr[i], rd_data[i] = the winning wb_data.
  - Otherwise rd_data[i] = the stored value.
- rd_busy[i] = cnt[rd_addr[i]] > hits(rd_addr[i]).
  - Ignores same-cycle issue: an instruction never depends on itself.
- Flush: on the edge, all counters are set to 0.
  - Same-cycle writebacks still write data.
  - A same-cycle issue is dropped, although iss_ready may still read 1.
- Reset, asynchronous:
  - All registers and all counters are set to 0.
  - Outputs during reset: rd_data = 0 unless bypassed, rd_busy = 0, iss_ready = 1, a0 = 0.
  - Reset in the middle of outstanding writes discards them.

## Timing
- Read: 0-cycle combinational path from rd_addr, wb_*, and stored state.
- Write: data is visible on rd_data in the same cycle via bypass, and in the array from the next cycle. a0 reflects a write one cycle after its edge.
- Issue: pending status shows on rd_busy from the cycle after acceptance.
- Counter values are registered only; there is no combinational path from iss_valid to iss_ready.
- Flush and reset take priority over issue. Flush does not block writeback data.

## Structure
- Package reg_file_pkg:
  - Typedefs: data_t, addr_t, pend_cnt_t.
  - Constants: REG_ZERO = 0, REG_A0 = 10.
- Sub-module reg_pend_tracker: the counter array, hit counting, iss_ready and busy computation. Parametrised by ADDRESS_WIDTH, NUM_WRITE, NUM_READ and PEND_W.
- Top level holds the data array, write priority, bypass muxes, and the a0 tap.

## Test plan
- Reset, then read every register on both ports -> all 0, rd_busy = 0, iss_ready = 1. Assert rst mid-run after writing x5 = 0x1234 -> x5 reads 0 immediately.
- Issue x7, then next cycle read x7 -> rd_busy = 1. Writeback x7 = 0xDEADBEEF while reading x7 -> rd_data = 0xDEADBEEF and rd_busy = 0 in that cycle; stored value is the same next cycle.
- Both writeback ports hit x3 with 0x11 (port 0) and 0x22 (port 1) -> rd_data = 0x22. If x3 had cnt 2, its counter goes to 0.
- Issue x9 three times with PEND_W = 2 -> iss_ready drops to 0 for x9 and a fourth issue is not counted. Then one writeback -> iss_ready = 1.
- Writeback x0 = 0xFFFF_FFFF and issue x0 -> x0 reads 0 and is never busy. Writeback x10 = 0x2A -> a0 = 0x2A on the next cycle.
- Issue x4 twice, then flush together with issue x6 and writeback x4 = 0x55 -> x4 and x6 not busy afterwards, x4 reads 0x55.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and architectural register numbers for the integer register file
// and its pending-write scoreboard.
package reg_file_pkg;

  localparam int D_WIDTH_DEF    = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int PEND_W_DEF     = 2;

  typedef logic [D_WIDTH_DEF-1:0]    data_t;
  typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
  typedef logic [PEND_W_DEF-1:0]     pend_cnt_t;

  localparam int unsigned REG_ZERO = 32'd0;
  localparam int unsigned REG_A0   = 32'd10;

endpackage

// File: rtl/reg_pend_tracker.sv
// Per-register outstanding-write counters: counts writeback hits, accepts issues
// and reports which read sources are still pending after this cycle's writebacks.
module reg_pend_tracker
  import reg_file_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_WRITE     = 2,
  parameter int NUM_READ      = 2,
  parameter int PEND_W        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
  output logic                              iss_ready,
  input  logic [NUM_WRITE-1:0]              wb_valid,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ-1:0]               rd_busy
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  // Two guard bits so hit counts up to NUM_WRITE compare cleanly against counts.
  localparam int CW    = PEND_W + 2;

  logic [PEND_W-1:0] cnt_q  [DEPTH];
  logic [PEND_W-1:0] cnt_d  [DEPTH];
  logic [CW-1:0]     hits_s [DEPTH];
  logic              acc_s;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      hits_s[r] = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wb_valid[w] && (r != int'(REG_ZERO)) &&
            (wb_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ADDRESS_WIDTH'(r))) begin
          hits_s[r] = hits_s[r] + CW'(1);
        end else begin
          hits_s[r] = hits_s[r];
        end
      end
    end
  end

  // Readiness comes from the registered count only; flush drops the issue.
  always_comb begin
    iss_ready = (iss_rd == ADDRESS_WIDTH'(REG_ZERO)) || (cnt_q[iss_rd] != {PEND_W{1'b1}});
    acc_s     = iss_valid && iss_ready && !flush;
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      if (flush || (r == int'(REG_ZERO))) begin
        cnt_d[r] = '0;
      end else if (CW'(cnt_q[r]) > hits_s[r]) begin
        cnt_d[r] = cnt_q[r] - hits_s[r][PEND_W-1:0]
                 + PEND_W'(acc_s && (iss_rd == ADDRESS_WIDTH'(r)));
      end else begin
        cnt_d[r] = PEND_W'(acc_s && (iss_rd == ADDRESS_WIDTH'(r)));
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_busy[i] = CW'(cnt_q[rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]])
                 > hits_s[rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with write-through read bypass, an a0 debug
// tap and a pending-write scoreboard used by the hazard unit.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 2,
  parameter int PEND_W        = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*D_WIDTH-1:0]        rd_data,
  output logic [NUM_READ-1:0]                rd_busy,
  input  logic                               iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]           iss_rd,
  output logic                               iss_ready,
  input  logic [NUM_WRITE-1:0]               wb_valid,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [NUM_WRITE*D_WIDTH-1:0]       wb_data,
  input  logic                               flush,
  output logic [D_WIDTH-1:0]                 a0
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] mem_d [DEPTH];

  reg_pend_tracker #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_WRITE     (NUM_WRITE),
    .NUM_READ      (NUM_READ),
    .PEND_W        (PEND_W)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

  // Ascending port order lets the highest-numbered port win a same-register write.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) mem_d[r] = mem_q[r];
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wb_valid[w] && (wb_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ADDRESS_WIDTH'(REG_ZERO))) begin
        mem_d[wb_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = wb_data[w*D_WIDTH +: D_WIDTH];
      end else begin
        mem_d[0] = mem_d[0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data[i*D_WIDTH +: D_WIDTH] = mem_q[rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wb_valid[w] &&
            (wb_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ADDRESS_WIDTH'(REG_ZERO)) &&
            (wb_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
          rd_data[i*D_WIDTH +: D_WIDTH] = wb_data[w*D_WIDTH +: D_WIDTH];
        end else begin
          rd_data[i*D_WIDTH +: D_WIDTH] = rd_data[i*D_WIDTH +: D_WIDTH];
        end
      end
    end
  end

  always_comb begin
    a0 = mem_q[ADDRESS_WIDTH'(REG_A0)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic        flush;
  logic [31:0] a0;

  localparam int K_RD0 = 0, K_RD1 = 1, K_BUSY0 = 2, K_BUSY1 = 3, K_READY = 4, K_A0 = 5;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] act;
  int          checks;
  int          failures;

  reg_file_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .a0        (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RD0:   return rd_data[31:0];
      K_RD1:   return rd_data[63:32];
      K_BUSY0: return {31'd0, rd_busy[0]};
      K_BUSY1: return {31'd0, rd_busy[1]};
      K_READY: return {31'd0, iss_ready};
      K_A0:    return a0;
      default: return 32'hXXXX_XXXX;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = actual(cur.kind);
      checks = checks + 1;
      if (act !== cur.exp) begin
        failures = failures + 1;
        $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic exp_v(input string name, input int kind, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    wb_valid  = 2'b00;
    flush     = 1'b0;
  endtask

  task automatic set_rd(input int a, input int b);
    rd_addr = {5'(b), 5'(a)};
  endtask

  task automatic do_wb(input int p, input int a, input logic [31:0] d);
    wb_valid[p]         = 1'b1;
    wb_addr[p*5 +: 5]   = 5'(a);
    wb_data[p*32 +: 32] = d;
  endtask

  task automatic issue(input int a);
    iss_valid = 1'b1;
    iss_rd    = 5'(a);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rd_addr = 10'd0; iss_valid = 1'b0; iss_rd = 5'd0;
    wb_valid = 2'b00; wb_addr = 10'd0; wb_data = 64'd0; flush = 1'b0;

    // Held in reset
    step(); set_rd(10, 0);
    exp_v("rst_rd0", K_RD0, 32'd0); exp_v("rst_busy0", K_BUSY0, 32'd0);
    exp_v("rst_ready", K_READY, 32'd1); exp_v("rst_a0", K_A0, 32'd0);
    #1;
    checks = checks + 1;
    if ((rd_data !== 64'd0) || (rd_busy !== 2'b00) || (iss_ready !== 1'b1) || (a0 !== 32'd0)) begin
      failures = failures + 1;
      $display("FAIL rst_direct: rd_data=%h rd_busy=%b iss_ready=%b a0=%h",
               rd_data, rd_busy, iss_ready, a0);
    end
    step(); rst = 1'b0;

    for (int r = 0; r < 32; r++) begin
      step(); set_rd(r, 31 - r); iss_rd = 5'(r);
      exp_v("init_rd0", K_RD0, 32'd0); exp_v("init_rd1", K_RD1, 32'd0);
      exp_v("init_busy0", K_BUSY0, 32'd0); exp_v("init_busy1", K_BUSY1, 32'd0);
      exp_v("init_ready", K_READY, 32'd1);
    end

    // x5 write then asynchronous reset mid-cycle
    step(); do_wb(0, 5, 32'h0000_1234); set_rd(5, 5);
    exp_v("x5_byp0", K_RD0, 32'h0000_1234); exp_v("x5_byp1", K_RD1, 32'h0000_1234);
    step(); exp_v("x5_stored", K_RD0, 32'h0000_1234);
    step(); rst = 1'b1;
    exp_v("x5_rst", K_RD0, 32'd0); exp_v("x5_rst_ready", K_READY, 32'd1);
    step(); rst = 1'b0; exp_v("x5_after_rst", K_RD0, 32'd0);

    // Issue x7, busy next cycle, writeback clears busy with bypass
    step(); issue(7); set_rd(7, 7);
    exp_v("x7_iss_ready", K_READY, 32'd1); exp_v("x7_self_busy", K_BUSY0, 32'd0);
    step(); exp_v("x7_busy", K_BUSY0, 32'd1); exp_v("x7_busy1", K_BUSY1, 32'd1);
    step(); do_wb(0, 7, 32'hDEAD_BEEF);
    exp_v("x7_byp", K_RD0, 32'hDEAD_BEEF); exp_v("x7_wb_busy", K_BUSY0, 32'd0);
    step(); exp_v("x7_stored", K_RD1, 32'hDEAD_BEEF); exp_v("x7_idle_busy", K_BUSY0, 32'd0);

    // x3 pending twice, both ports write it in one cycle
    step(); issue(3); set_rd(3, 3);
    step(); issue(3);
    step(); exp_v("x3_busy", K_BUSY0, 32'd1);
    step(); do_wb(0, 3, 32'h0000_0011); do_wb(1, 3, 32'h0000_0022);
    exp_v("x3_win0", K_RD0, 32'h0000_0022); exp_v("x3_win1", K_RD1, 32'h0000_0022);
    exp_v("x3_dual_busy", K_BUSY0, 32'd0);
    step(); exp_v("x3_stored", K_RD0, 32'h0000_0022); exp_v("x3_cnt0", K_BUSY0, 32'd0);

    // Different regs on the two ports
    step(); do_wb(0, 12, 32'h0000_000A); do_wb(1, 13, 32'h0000_000B); set_rd(13, 12);
    exp_v("x13_byp", K_RD0, 32'h0000_000B); exp_v("x12_byp", K_RD1, 32'h0000_000A);

    // x9 saturates at three outstanding writes
    step(); issue(9); set_rd(9, 9); exp_v("x9_rdy1", K_READY, 32'd1);
    step(); issue(9); exp_v("x9_rdy2", K_READY, 32'd1);
    step(); issue(9); exp_v("x9_rdy3", K_READY, 32'd1);
    step(); issue(9); exp_v("x9_full", K_READY, 32'd0); exp_v("x9_busy", K_BUSY0, 32'd1);
    step(); do_wb(0, 9, 32'h0000_0099); iss_rd = 5'd9;
    exp_v("x9_wb_rdy", K_READY, 32'd0); exp_v("x9_wb_busy", K_BUSY0, 32'd1);
    exp_v("x9_byp", K_RD0, 32'h0000_0099);
    step(); exp_v("x9_rdy_back", K_READY, 32'd1);
    step(); do_wb(1, 9, 32'h0000_0098); exp_v("x9_cnt2_busy", K_BUSY0, 32'd1);
    step(); do_wb(0, 9, 32'h0000_0097); exp_v("x9_cnt1_busy", K_BUSY0, 32'd0);
    step(); exp_v("x9_drained", K_BUSY0, 32'd0); exp_v("x9_last", K_RD0, 32'h0000_0097);

    // Writeback to an idle register stays at zero, later issue counts once
    step(); do_wb(0, 20, 32'h0000_0077); set_rd(20, 20); exp_v("x20_idle_busy", K_BUSY0, 32'd0);
    step(); issue(20); exp_v("x20_rd", K_RD0, 32'h0000_0077);
    step(); exp_v("x20_busy", K_BUSY0, 32'd1);
    step(); do_wb(0, 20, 32'h0000_0078); exp_v("x20_clear", K_BUSY0, 32'd0);

    // x0 is never written nor pending; a0 tap lags one cycle
    step(); do_wb(1, 0, 32'hFFFF_FFFF); issue(0); set_rd(0, 0);
    exp_v("x0_rd", K_RD0, 32'd0); exp_v("x0_busy", K_BUSY0, 32'd0); exp_v("x0_ready", K_READY, 32'd1);
    step(); exp_v("x0_rd_next", K_RD1, 32'd0); exp_v("x0_busy_next", K_BUSY1, 32'd0);
    step(); do_wb(0, 10, 32'h0000_002A); set_rd(10, 0);
    exp_v("a0_before", K_A0, 32'd0); exp_v("x10_byp", K_RD0, 32'h0000_002A);
    step(); exp_v("a0_after", K_A0, 32'h0000_002A);

    // Flush with same-cycle issue and writeback
    step(); issue(4); set_rd(4, 6);
    step(); issue(4);
    step(); exp_v("x4_busy", K_BUSY0, 32'd1);
    step(); flush = 1'b1; issue(6); do_wb(0, 4, 32'h0000_0055);
    exp_v("fl_x4_byp", K_RD0, 32'h0000_0055); exp_v("fl_x4_busy", K_BUSY0, 32'd1);
    exp_v("fl_x6_busy", K_BUSY1, 32'd0);
    step(); exp_v("fl_x4_clear", K_BUSY0, 32'd0); exp_v("fl_x6_clear", K_BUSY1, 32'd0);
    exp_v("fl_x4_data", K_RD0, 32'h0000_0055);

    step();
    step();
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL expired: %0d expectation(s) never compared", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
